// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared constants for the pipeline sequencing unit.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Stage index names for the classic 5-stage arrangement and the default
// pipeline depth / counter width used by pipe_stage_ctrl.
package pipe_stage_ctrl_pkg;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXE = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam int DEF_STAGES = 5;
    localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Four performance counters sharing a common advance qualifier.
// Latency: counts update on the edge after the increment enable is seen.
// Backpressure: none; counters only move when adv is high, and wrap silently.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   adv                 pipeline advances this cycle (gates every counter)
//   stall_inc/flush_inc/retire_inc  per-counter increment enables
//   cycle_cnt/stall_cnt/flush_cnt/retire_cnt  counter values
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             stall_inc,
    input  logic             flush_inc,
    input  logic             retire_inc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else if (adv) begin
            cycle_cnt <= cycle_cnt + ONE;
            if (stall_inc)  stall_cnt  <= stall_cnt + ONE;
            if (flush_inc)  flush_cnt  <= flush_cnt + ONE;
            if (retire_inc) retire_cnt <= retire_cnt + ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline sequencing: per-stage load/bubble enables, valid tracking, debug step, perf counters.
// Latency: stage_en/stage_rst combinational from requests and valids; stage_valid one edge later.
// Backpressure: a stall freezes stages 0..k and bubbles k+1; debug mode holds everything between steps.
//
// Ports:
//   clk, rst                core clock, synchronous active-high reset
//   debug_en, debug_step    single-step mode and step request (rising edge = one advance)
//   stall_req, flush_req    per-stage requests, ignored for invalid stages
//   stage_en, stage_rst     per-stage register load / bubble-load (rst wins over en)
//   stage_valid             registered per-stage valid bits
//   cycle/stall/flush/retire_cnt  performance counters
module pipe_stage_ctrl
    import pipe_stage_ctrl_pkg::*;
#(
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic [STAGES-1:0] stall_req,
    input  logic [STAGES-1:0] flush_req,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_rst,
    output logic [STAGES-1:0] stage_valid,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic              step_q;
    logic              adv;
    logic [STAGES-1:0] stall_eff;
    logic [STAGES-1:0] flush_eff;
    int                stall_top;   // -1 when no effective stall
    int                flush_top;   // 0 when no effective flush (stage 0 cannot flush)
    logic              stall_win;
    logic              flush_win;
    logic              retire_inc;

    always_comb begin
        adv = ~debug_en | (debug_step & ~step_q);

        stall_eff = stall_req & stage_valid;
        flush_eff = flush_req & stage_valid;
        // The IF stage just takes the redirected PC, so its own flush means nothing.
        flush_eff[STG_IF] = 1'b0;

        stall_top = -1;
        flush_top = 0;
        for (int i = 0; i < STAGES; i++) begin
            if (stall_eff[i]) stall_top = i;
            if (flush_eff[i]) flush_top = i;
        end

        // An older flush makes the stalling instruction wrong-path, so flush wins;
        // otherwise the flushing instruction is frozen and will re-request.
        flush_win = (flush_top > 0) && (flush_top > stall_top);
        stall_win = (stall_top >= 0) && !flush_win;

        stage_en  = '0;
        stage_rst = '0;
        if (rst) begin
            stage_rst = '1;
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                if (flush_win) begin
                    stage_en[i]  = 1'b1;
                    stage_rst[i] = (i >= STG_ID) && (i <= flush_top);
                end else if (stall_win) begin
                    stage_en[i]  = (i > stall_top);
                    stage_rst[i] = (i == stall_top + 1);
                end else begin
                    stage_en[i]  = 1'b1;
                end
            end
        end
    end

    assign retire_inc = stage_valid[STAGES-1] & stage_en[STAGES-1];

    // step_q resets high so a step held through reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q      <= 1'b1;
            stage_valid <= '0;
        end else begin
            step_q <= debug_step;
            if (adv) begin
                stage_valid[STG_IF] <= 1'b1;
                for (int i = 1; i < STAGES; i++) begin
                    if (stage_rst[i])
                        stage_valid[i] <= 1'b0;
                    else if (stage_en[i])
                        stage_valid[i] <= stage_valid[i-1];
                end
            end
        end
    end

    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .adv        (adv),
        .stall_inc  (stall_win),
        .flush_inc  (flush_win),
        .retire_inc (retire_inc),
        .cycle_cnt  (cycle_cnt),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .retire_cnt (retire_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: directed scenarios plus randomized traffic.
// Latency: one tick per clock; comb outputs checked mid-cycle, registered ones after the edge.
// Backpressure: n/a.
module tb_pipe_stage_ctrl;

    localparam int S = 5;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         debug_en = 1'b0;
    logic         debug_step = 1'b0;
    logic [S-1:0] stall_req = '0;
    logic [S-1:0] flush_req = '0;
    logic [S-1:0] stage_en;
    logic [S-1:0] stage_rst;
    logic [S-1:0] stage_valid;
    logic [W-1:0] cycle_cnt;
    logic [W-1:0] stall_cnt;
    logic [W-1:0] flush_cnt;
    logic [W-1:0] retire_cnt;

    pipe_stage_ctrl #(
        .STAGES (S),
        .CNT_W  (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .debug_en    (debug_en),
        .debug_step  (debug_step),
        .stall_req   (stall_req),
        .flush_req   (flush_req),
        .stage_en    (stage_en),
        .stage_rst   (stage_rst),
        .stage_valid (stage_valid),
        .cycle_cnt   (cycle_cnt),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pipeline occupancy as a bit array, decisions derived
    // from the priority rules with plain arithmetic on the top indices.
    bit           m_valid [S];
    bit           m_stepq = 1'b1;
    logic [W-1:0] m_cyc = '0, m_stall = '0, m_flush = '0, m_retire = '0;
    logic [S-1:0] e_en, e_rst;
    bit           e_adv;
    int           e_act;   // 0 none, 1 stall, 2 flush

    logic [S-1:0] en_seen, rst_seen;

    function automatic logic [S-1:0] m_vec();
        logic [S-1:0] v;
        for (int i = 0; i < S; i++) v[i] = m_valid[i];
        return v;
    endfunction

    task automatic model_eval();
        int ks, ms;
        e_adv = !debug_en || (debug_step && !m_stepq);
        e_act = 0;
        e_en  = '0;
        e_rst = '0;
        if (rst) begin
            e_rst = '1;
        end else if (e_adv) begin
            ks = -1;
            ms = 0;
            for (int i = 0; i < S; i++) if (stall_req[i] && m_valid[i]) ks = i;
            for (int i = 1; i < S; i++) if (flush_req[i] && m_valid[i]) ms = i;
            if (ms > 0 && ms > ks) begin
                e_act = 2;
                e_en  = '1;
                e_rst = S'((1 << (ms + 1)) - 2);
            end else if (ks >= 0) begin
                e_act = 1;
                e_en  = S'(~((1 << (ks + 1)) - 1));
                e_rst = S'(1 << (ks + 1));
            end else begin
                e_en = '1;
            end
        end
    endtask

    task automatic model_commit();
        bit old [S];
        if (rst) begin
            for (int i = 0; i < S; i++) m_valid[i] = 1'b0;
            m_stepq = 1'b1;
            m_cyc = '0; m_stall = '0; m_flush = '0; m_retire = '0;
        end else begin
            if (e_adv) begin
                old = m_valid;
                if (old[S-1] && e_en[S-1]) m_retire++;
                m_valid[0] = 1'b1;
                for (int i = 1; i < S; i++)
                    m_valid[i] = e_rst[i] ? 1'b0 : (e_en[i] ? old[i-1] : old[i]);
                m_cyc++;
                if (e_act == 1) m_stall++;
                if (e_act == 2) m_flush++;
            end
            m_stepq = debug_step;
        end
    endtask

    task automatic tick(input logic r, input logic de, input logic ds,
                        input logic [S-1:0] st, input logic [S-1:0] fl);
        rst = r; debug_en = de; debug_step = ds; stall_req = st; flush_req = fl;
        #2;
        model_eval();
        en_seen  = stage_en;
        rst_seen = stage_rst;
        chk("stage_en", stage_en, e_en);
        chk("stage_rst", stage_rst, e_rst);
        @(posedge clk);
        model_commit();
        #1;
        chk("stage_valid", stage_valid, m_vec());
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        chk("retire_cnt", retire_cnt, m_retire);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    logic [W-1:0] snap_a, snap_b;
    logic         r_de, r_ds;

    initial begin
        for (int i = 0; i < S; i++) m_valid[i] = 1'b0;

        // 1. reset and fill
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0, '0);
            chk("rst_en", en_seen, 5'b00000);
            chk("rst_rst", rst_seen, 5'b11111);
            chk("rst_valid", stage_valid, 5'b00000);
            chk("rst_cycle", cycle_cnt, 0);
        end
        idle(1);
        chk("fill_en", en_seen, 5'b11111);
        chk("fill_rst", rst_seen, 5'b00000);
        idle(4);
        chk("fill_valid", stage_valid, 5'b11111);
        chk("fill_cycle", cycle_cnt, 5);

        // 2. load-use stall at ID
        tick(1'b0, 1'b0, 1'b0, 5'b00010, 5'b00000);
        chk("stall_en", en_seen, 5'b11100);
        chk("stall_rst", rst_seen, 5'b00100);
        chk("stall_valid", stage_valid, 5'b11011);
        chk("stall_cnt1", stall_cnt, 1);
        idle(4);

        // 3. branch flush at EXE
        tick(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00100);
        chk("flush_en", en_seen, 5'b11111);
        chk("flush_rst", rst_seen, 5'b00110);
        chk("flush_valid", stage_valid, 5'b11001);
        chk("flush_cnt1", flush_cnt, 1);
        idle(4);

        // 4a. older flush beats younger stall
        tick(1'b0, 1'b0, 1'b0, 5'b00010, 5'b00100);
        chk("sf_en", en_seen, 5'b11111);
        chk("sf_rst", rst_seen, 5'b00110);
        chk("sf_stall_cnt", stall_cnt, 1);
        chk("sf_flush_cnt", flush_cnt, 2);
        idle(4);

        // 4b. older stall suppresses younger flush
        tick(1'b0, 1'b0, 1'b0, 5'b01000, 5'b00100);
        chk("fs_en", en_seen, 5'b10000);
        chk("fs_rst", rst_seen, 5'b10000);
        chk("fs_flush_cnt", flush_cnt, 2);
        chk("fs_valid", stage_valid, 5'b01111);
        idle(4);

        // 6. masking: make ID invalid, then a stall from ID is ignored
        tick(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00010);
        chk("mask_pre_valid", stage_valid, 5'b11101);
        snap_a = stall_cnt;
        tick(1'b0, 1'b0, 1'b0, 5'b00010, 5'b00000);
        chk("mask_en", en_seen, 5'b11111);
        chk("mask_stall_cnt", stall_cnt, snap_a);
        idle(4);
        snap_a = retire_cnt;
        idle(10);
        chk("retire_10", retire_cnt, snap_a + 10);

        // 5. debug stepping
        snap_a = cycle_cnt;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 1'b0, '0, '0);
            chk("dbg_hold_en", en_seen, 5'b00000);
        end
        chk("dbg_hold_cycle", cycle_cnt, snap_a);
        chk("dbg_hold_valid", stage_valid, 5'b11111);
        tick(1'b0, 1'b1, 1'b1, '0, '0);
        chk("dbg_step_en", en_seen, 5'b11111);
        tick(1'b0, 1'b1, 1'b1, '0, '0);
        chk("dbg_held_en", en_seen, 5'b00000);
        tick(1'b0, 1'b1, 1'b1, '0, '0);
        chk("dbg_one_step", cycle_cnt, snap_a + 1);
        tick(1'b0, 1'b1, 1'b0, '0, '0);
        tick(1'b1, 1'b1, 1'b1, '0, '0);
        tick(1'b1, 1'b1, 1'b1, '0, '0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, '0, '0);
        chk("dbg_rst_cycle", cycle_cnt, 0);
        chk("dbg_rst_valid", stage_valid, 5'b00000);
        tick(1'b0, 1'b1, 1'b0, '0, '0);
        tick(1'b0, 1'b1, 1'b1, '0, '0);
        chk("dbg_after_rst", cycle_cnt, 1);

        // randomized traffic against the model
        r_de = 1'b0;
        r_ds = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(39) == 0) r_de = ~r_de;
            if ($urandom_range(2) == 0) r_ds = ~r_ds;
            tick($urandom_range(63) == 0, r_de, r_ds,
                 S'($urandom & $urandom & $urandom),
                 S'($urandom & $urandom & $urandom));
        end
        snap_b = cycle_cnt;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
